// File: rtl/imem_loader_rv32i.sv
// imem_loader_rv32i: byte-stream boot loader that fills the RV32I instruction memory and releases the CPU reset once the checksum matches
// Ports: clock/reset (async, active-high); in_valid/in_data/in_ready byte stream; reload restarts from DONE or ERROR;
// imem_we/imem_waddr/imem_wdata instruction-memory write port; cpu_reset, load_done, load_error, words_loaded status.
module imem_loader_rv32i #(
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          load_done,
  output logic          load_error,
  output logic [15:0]   words_loaded
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;
  localparam logic [16:0] CAP = 17'(1) << AW;
  state_t        state_q, state_d;
  logic [15:0]   n_q, n_d, cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   sh_q, sh_d;
  logic [7:0]    sum_q, sum_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          acc;
  assign in_ready     = (state_q != DONE) && (state_q != ERR);
  assign acc          = in_valid & in_ready;
  assign cpu_reset    = state_q != DONE;
  assign load_done    = state_q == DONE;
  assign load_error   = state_q == ERR;
  assign imem_we      = we_q;
  assign imem_waddr   = addr_q;
  assign imem_wdata   = data_q;
  assign words_loaded = cnt_q;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (acc) begin
      case (state_q)
        HDR0: begin
          n_d[7:0] = in_data;
          state_d  = HDR1;
        end
        HDR1: begin
          n_d[15:8] = in_data;
          state_d   = ({1'b0, in_data, n_q[7:0]} > CAP) ? ERR :
                      ({in_data, n_q[7:0]} == 16'd0) ? CHK : DATA;
        end
        DATA: begin
          sum_d = sum_q + in_data;
          idx_d = idx_q + 2'd1;
          sh_d  = {in_data, sh_q[23:8]};
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = cnt_q[AW-1:0];
            data_d  = {in_data, sh_q};
            cnt_d   = cnt_q + 16'd1;
            state_d = (cnt_q == n_q - 16'd1) ? CHK : DATA;
          end
        end
        CHK:     state_d = (in_data == sum_q) ? DONE : ERR;
        default: state_d = state_q;
      endcase
    end
    if (reload && !in_ready) begin
      state_d = HDR0;
      sum_d   = 8'd0;
      cnt_d   = 16'd0;
      idx_d   = 2'd0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HDR0;
      n_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_imem_loader_rv32i.sv
// tb_imem_loader_rv32i: scoreboard bench for the instruction-memory boot loader
module tb_imem_loader_rv32i;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        reload = 1'b0;
  logic        in_ready, imem_we, cpu_reset, load_done, load_error;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [15:0] words_loaded;
  int          checks = 0;
  int          errors = 0;
  logic [39:0] sb[$];
  logic [31:0] prog[0:511];

  imem_loader_rv32i #(.AW(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && imem_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", {imem_waddr, imem_wdata});
      end else chk("write", {imem_waddr, imem_wdata}, sb.pop_front());
    end
  end

  task automatic send(input logic [7:0] b, input bit thr);
    if (thr) repeat ($urandom_range(0, 3)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(negedge clock);
    end
    in_valid = 1'b1;
    in_data  = b;
    chk("in_ready", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic load(input int n, input bit bad, input bit thr);
    int sum = 0;
    bit err;
    if (n <= 256) for (int i = 0; i < n; i++) sb.push_back({8'(i), prog[i]});
    send(n[7:0], thr);
    send(n[15:8], thr);
    if (n > 256) err = 1'b1;
    else begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) begin
          sum += prog[i][8*k +: 8];
          send(prog[i][8*k +: 8], thr);
        end
      err = bad;
      send(8'(sum + int'(bad)), thr);
    end
    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    chk("load_done", load_done, !err);
    chk("load_error", load_error, err);
    chk("cpu_reset", cpu_reset, err);
    chk("in_ready_end", in_ready, 0);
    chk("words_loaded", words_loaded, (n > 256) ? 0 : n);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
    chk("rl_cpu_reset", cpu_reset, 1);
    chk("rl_in_ready", in_ready, 1);
    chk("rl_done", load_done, 0);
    chk("rl_error", load_error, 0);
    chk("rl_words", words_loaded, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_waddr", imem_waddr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", load_done, 0);
    chk("rst_error", load_error, 0);
    chk("rst_words", words_loaded, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_reset_vals();
    prog[0] = 32'h00500093;
    prog[1] = 32'h00100113;
    load(2, 0, 0);
    do_reload();
    load(2, 1, 0);
    do_reload();
    load(0, 0, 0);
    do_reload();
    load(257, 0, 0);
    do_reload();
    prog[0] = $urandom;
    load(1, 0, 1);
    do_reload();
    load(1, 0, 0);
    do_reload();
    prog[0] = $urandom;
    prog[1] = $urandom;
    sb.push_back({8'd0, prog[0]});
    send(8'd2, 0);
    send(8'd0, 0);
    for (int j = 0; j < 6; j++) send(prog[j/4][8*(j%4) +: 8], 0);
    chk("mid_sb_drained", sb.size(), 0);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    load(2, 0, 0);
    do_reload();
    for (int i = 0; i < 256; i++) prog[i] = $urandom;
    load(256, 0, 0);
    do_reload();
    for (int t = 0; t < 15; t++) begin
      int n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      load(n, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      do_reload();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
